// File: rtl/rv_regs_pkg.sv
// Shared types and helpers for the multi-port RV32 integer register file.
package rv_regs_pkg;

    localparam int RV_XLEN       = 32;
    localparam int RV_REG_ADDR_W = 5;

    typedef logic [RV_REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regs_clr_state_t;

    // RV32E exposes only x0..x15, so an address is usable only below the register count.
    function automatic logic addr_ok(input reg_addr_t a, input int nregs);
        return (int'(a) < nregs);
    endfunction

endpackage

// File: rtl/rv_regs_mp_if.sv
// Decode/writeback-facing bus of the register file: packed read/write ports plus status.
interface rv_regs_mp_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    logic [NRD*5-1:0]    i_rs;
    logic [NWR*5-1:0]    i_rd;
    logic [NWR-1:0]      i_write;
    logic [NWR*XLEN-1:0] i_data;
    logic [NRD*XLEN-1:0] o_data;
    logic                o_busy;
    logic                o_bad_addr;

    modport master (
        output i_rs, i_rd, i_write, i_data,
        input  o_data, o_busy, o_bad_addr
    );

    modport slave (
        input  i_rs, i_rd, i_write, i_data,
        output o_data, o_busy, o_bad_addr
    );
endinterface

// File: rtl/rv_regs_clear.sv
// Post-reset clear sequencer: walks x1..x(NREGS-1) writing zero, holding busy meanwhile.
module rv_regs_clear
    import rv_regs_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int ENABLE = 1
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    output logic      o_busy,
    output logic      o_clr_we,
    output reg_addr_t o_clr_addr
);

    regs_clr_state_t r_state;
    reg_addr_t       r_cnt;
    logic            r_busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= (ENABLE != 0) ? CLEAR : READY;
            r_cnt   <= reg_addr_t'(1);
            r_busy  <= (ENABLE != 0);
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == reg_addr_t'(NREGS - 1)) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + reg_addr_t'(1);
                    end
                end
                READY:   r_state <= READY;
                default: r_state <= READY;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/rv_regs_mp.sv
// Multi-port RV32 integer register file: one RAM bank per write port, LVT select for two
// writers, registered reads, with x0/range/bypass handling kept outside the banks.
module rv_regs_mp
    import rv_regs_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int CLEAR  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rv_regs_mp_if.slave   bus
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic            w_busy;
    logic            w_clr_we;
    reg_addr_t       w_clr_addr;
    reg_addr_t       w_waddr     [NWR];
    logic [XLEN-1:0] w_wdata     [NWR];
    logic [NWR-1:0]  w_we;
    logic [NWR-1:0]  w_bank_we;
    reg_addr_t       w_bank_addr [NWR];
    logic [XLEN-1:0] w_bank_data [NWR];
    reg_addr_t       w_rs        [NRD];
    logic [XLEN-1:0] w_bank_q    [NWR][NRD];
    logic            w_lvt_q     [NRD];
    logic            w_bad_next;
    logic            r_bad;

    rv_regs_clear #(
        .NREGS  (NREGS),
        .ENABLE (CLEAR)
    ) u_clear (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    generate
        for (genvar gi = 0; gi < NWR; gi++) begin : g_wport
            assign w_waddr[gi] = bus.i_rd[gi*RV_REG_ADDR_W +: RV_REG_ADDR_W];
            assign w_wdata[gi] = bus.i_data[gi*XLEN +: XLEN];
            assign w_we[gi]    = bus.i_write[gi] && !w_busy
                               && addr_ok(w_waddr[gi], NREGS) && (w_waddr[gi] != '0);
            // The clear sequencer borrows write port 0 while external writes are gated off.
            if (gi == 0) begin : g_clr_mux
                assign w_bank_we[gi]   = w_clr_we || w_we[gi];
                assign w_bank_addr[gi] = w_clr_we ? w_clr_addr : w_waddr[gi];
                assign w_bank_data[gi] = w_clr_we ? '0 : w_wdata[gi];
            end else begin : g_direct
                assign w_bank_we[gi]   = w_we[gi];
                assign w_bank_addr[gi] = w_waddr[gi];
                assign w_bank_data[gi] = w_wdata[gi];
            end
        end

        for (genvar gi = 0; gi < NWR; gi++) begin : g_bank
            logic [XLEN-1:0] r_mem [NREGS];

            always_ff @(posedge i_clk) begin
                if (w_bank_we[gi]) begin
                    r_mem[w_bank_addr[gi][AW-1:0]] <= w_bank_data[gi];
                end
            end

            for (genvar gj = 0; gj < NRD; gj++) begin : g_rd
                logic [XLEN-1:0] r_q;
                always_ff @(posedge i_clk) begin
                    r_q <= r_mem[w_rs[gj][AW-1:0]];
                end
                assign w_bank_q[gi][gj] = r_q;
            end
        end

        // Live-value table: remembers which bank holds the newest copy; port 1 is written last so it wins.
        if (NWR == 2) begin : g_lvt
            logic r_lvt [NREGS];

            always_ff @(posedge i_clk) begin
                if (w_bank_we[0]) r_lvt[w_bank_addr[0][AW-1:0]] <= 1'b0;
                if (w_bank_we[1]) r_lvt[w_bank_addr[1][AW-1:0]] <= 1'b1;
            end

            for (genvar gj = 0; gj < NRD; gj++) begin : g_rd
                logic r_q;
                always_ff @(posedge i_clk) begin
                    r_q <= r_lvt[w_rs[gj][AW-1:0]];
                end
                assign w_lvt_q[gj] = r_q;
            end
        end else begin : g_no_lvt
            for (genvar gj = 0; gj < NRD; gj++) begin : g_rd
                assign w_lvt_q[gj] = 1'b0;
            end
        end

        for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
            logic            r_zero;
            logic            r_hit;
            logic [XLEN-1:0] r_byp;
            logic            w_hit_next;
            logic [XLEN-1:0] w_byp_next;

            assign w_rs[gi] = bus.i_rs[gi*RV_REG_ADDR_W +: RV_REG_ADDR_W];

            always_comb begin
                w_hit_next = 1'b0;
                w_byp_next = '0;
                for (int w = 0; w < NWR; w++) begin
                    if (w_we[w] && (w_waddr[w] == w_rs[gi])) begin
                        w_hit_next = 1'b1;
                        w_byp_next = w_wdata[w];
                    end
                end
            end

            // Control side carries the async reset so o_data drops to zero without a clock.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_zero <= 1'b1;
                    r_hit  <= 1'b0;
                    r_byp  <= '0;
                end else begin
                    r_zero <= w_busy || (w_rs[gi] == '0) || !addr_ok(w_rs[gi], NREGS);
                    r_hit  <= (BYPASS != 0) && w_hit_next;
                    r_byp  <= w_byp_next;
                end
            end

            assign bus.o_data[gi*XLEN +: XLEN] =
                r_zero     ? '0 :
                r_hit      ? r_byp :
                w_lvt_q[gi] ? w_bank_q[NWR-1][gi] : w_bank_q[0][gi];
        end
    endgenerate

    always_comb begin
        w_bad_next = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (!addr_ok(w_rs[p], NREGS)) w_bad_next = 1'b1;
        end
        for (int w = 0; w < NWR; w++) begin
            if (bus.i_write[w] && !addr_ok(w_waddr[w], NREGS)) w_bad_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bad <= 1'b0;
        end else begin
            r_bad <= w_bad_next;
        end
    end

    assign bus.o_busy     = w_busy;
    assign bus.o_bad_addr = r_bad;

endmodule

// File: tb/tb_rv_regs_mp.sv
// Scoreboard bench: dut A is RV32I with two write ports and bypass, dut B is RV32E, one writer, no bypass.
module tb_rv_regs_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_regs_mp_if #(.XLEN(32), .NRD(2), .NWR(2)) ifa ();
    rv_regs_mp_if #(.XLEN(32), .NRD(2), .NWR(1)) ifb ();

    rv_regs_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .CLEAR(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifa)
    );
    rv_regs_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(1), .BYPASS(0), .CLEAR(1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifb)
    );

    typedef struct {
        int          due;
        int          dut;
        int          kind;   // 0 data, 1 busy, 2 bad_addr
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [31:0] get_act(int dut, int kind, int port);
        if (dut == 0) begin
            if (kind == 0) return ifa.o_data[port*32 +: 32];
            if (kind == 1) return {31'b0, ifa.o_busy};
            return {31'b0, ifa.o_bad_addr};
        end
        if (kind == 0) return ifb.o_data[port*32 +: 32];
        if (kind == 1) return {31'b0, ifb.o_busy};
        return {31'b0, ifb.o_bad_addr};
    endfunction

    // Monitor: every falling edge, compare all expectations due for the current cycle.
    always @(negedge clk) begin : mon
        exp_t        e;
        string       nm;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = get_act(e.dut, e.kind, e.port);
            n_vec++;
            if (e.due != cyc || act !== e.val) begin
                n_err++;
                $display("FAIL %s dut%0d kind%0d port%0d: got %h expected %h (cycle %0d)",
                         nm, e.dut, e.kind, e.port, act, e.val, cyc);
            end else begin
                $display("chk %s dut%0d kind%0d port%0d = %h ok", nm, e.dut, e.kind, e.port, act);
            end
        end
    end

    task automatic push(int dut, int kind, int port, logic [31:0] val, string nm, int off);
        exp_t e;
        e.due = cyc + off; e.dut = dut; e.kind = kind; e.port = port; e.val = val;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_a(logic [31:0] v0, logic [31:0] v1, string nm);
        push(0, 0, 0, v0, nm, 1);
        push(0, 0, 1, v1, nm, 1);
        push(0, 2, 0, 32'd0, nm, 1);
    endtask

    task automatic exp_b(logic [31:0] v0, logic [31:0] v1, logic bad, string nm);
        push(1, 0, 0, v0, nm, 1);
        push(1, 0, 1, v1, nm, 1);
        push(1, 2, 0, {31'b0, bad}, nm, 1);
    endtask

    task automatic drv_a(logic [1:0] we, logic [4:0] rd0, logic [31:0] d0,
                         logic [4:0] rd1, logic [31:0] d1, logic [4:0] rs0, logic [4:0] rs1);
        ifa.i_write = we;
        ifa.i_rd    = {rd1, rd0};
        ifa.i_data  = {d1, d0};
        ifa.i_rs    = {rs1, rs0};
    endtask

    task automatic drv_b(logic we, logic [4:0] rd, logic [31:0] d, logic [4:0] rs0, logic [4:0] rs1);
        ifb.i_write = we;
        ifb.i_rd    = rd;
        ifb.i_data  = d;
        ifb.i_rs    = {rs1, rs0};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_run(bit poke);
        for (int i = 0; i < 33; i++) begin
            push(0, 1, 0, (i < 30) ? 32'd1 : 32'd0, "busy_a", 1);
            push(1, 1, 0, (i < 14) ? 32'd1 : 32'd0, "busy_b", 1);
            if (poke && i == 5) begin
                drv_a(2'b01, 5'd2, 32'h55, 5'd0, 32'h0, 5'd0, 5'd0);
                drv_b(1'b1, 5'd2, 32'h66, 5'd0, 5'd0);
            end else begin
                drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
                drv_b(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            end
            tick();
        end
    endtask

    initial begin
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) tick();

        // Reset state while held
        exp_a(32'h0, 32'h0, "reset_a");
        exp_b(32'h0, 32'h0, 1'b0, "reset_b");
        push(0, 1, 0, 32'd1, "reset_busy_a", 1);
        push(1, 1, 0, 32'd1, "reset_busy_b", 1);
        tick();
        rst_n = 1'b1;

        // Clear sequence, with an external write to x2 that must be ignored
        clear_run(1'b1);

        // Every register reads back zero after clear
        for (int k = 1; k <= 31; k += 2) begin
            drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(k), (k < 31) ? 5'(k + 1) : 5'd0);
            drv_b(1'b0, 5'd0, 32'h0, (k < 16) ? 5'(k) : 5'd0, (k < 15) ? 5'(k + 1) : 5'd0);
            exp_a(32'h0, 32'h0, "clear_rd_a");
            exp_b(32'h0, 32'h0, 1'b0, "clear_rd_b");
            tick();
        end

        // Write then read next cycle
        drv_a(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0);
        drv_b(1'b1, 5'd5, 32'hCAFEF00D, 5'd0, 5'd0);
        exp_a(32'h0, 32'h0, "wr5_a");
        exp_b(32'h0, 32'h0, 1'b0, "wr5_b");
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        exp_a(32'hDEADBEEF, 32'h0, "rd5_a");
        exp_b(32'hCAFEF00D, 32'h0, 1'b0, "rd5_b");
        tick();

        // Same-cycle write/read: bypass on A, old value on B
        drv_a(2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 5'd7, 5'd5);
        drv_b(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5);
        exp_a(32'h12345678, 32'hDEADBEEF, "bypass_a");
        exp_b(32'h0, 32'hCAFEF00D, 1'b0, "nobypass_b");
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        exp_a(32'h12345678, 32'h0, "rd7_a");
        exp_b(32'h12345678, 32'h0, 1'b0, "rd7_b");
        tick();

        // Dual write to x9: port 1 wins, also through bypass
        drv_a(2'b11, 5'd9, 32'h1111, 5'd9, 32'h2222, 5'd9, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        exp_a(32'h2222, 32'h0, "dual_byp_a");
        tick();
        drv_a(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 5'd9, 5'd0);
        exp_a(32'h2222, 32'h0, "x0_wr_a");
        tick();
        drv_a(2'b11, 5'd10, 32'hA, 5'd11, 32'hB, 5'd11, 5'd10);
        exp_a(32'hB, 32'hA, "split_byp_a");
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9);
        exp_a(32'h0, 32'h2222, "x0_rd_a");
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11);
        exp_a(32'hA, 32'hB, "lvt_rd_a");
        tick();

        // RV32E out-of-range access
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        drv_b(1'b1, 5'd4, 32'h4444, 5'd0, 5'd0);
        exp_b(32'h0, 32'h0, 1'b0, "wr4_b");
        tick();
        drv_b(1'b1, 5'd20, 32'hAAAA, 5'd20, 5'd4);
        exp_b(32'h0, 32'h4444, 1'b1, "range_b");
        tick();
        drv_b(1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
        exp_b(32'h4444, 32'h0, 1'b0, "range_after_b");
        tick();

        // Reset mid-operation: outputs clear without waiting for an edge
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd20, 5'd0);
        exp_a(32'hDEADBEEF, 32'h0, "pre_rst_a");
        push(1, 2, 0, 32'd1, "pre_rst_bad_b", 1);
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(0, 0, 0, 32'h0, "async_rst_data_a", 0);
        push(1, 2, 0, 32'd0, "async_rst_bad_b", 0);
        push(0, 1, 0, 32'd1, "async_rst_busy_a", 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset again at clear cycle 10
        for (int i = 0; i < 10; i++) begin
            push(0, 1, 0, 32'd1, "busy_mid_a", 1);
            tick();
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(0, 0, 0, 32'h0, "midclr_data_a", 0);
        push(0, 1, 0, 32'd1, "midclr_busy_a", 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_run(1'b0);

        // Re-cleared contents
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd9);
        drv_b(1'b0, 5'd0, 32'h0, 5'd4, 5'd7);
        exp_a(32'h0, 32'h0, "reclr_a");
        exp_b(32'h0, 32'h0, 1'b0, "reclr_b");
        tick();
        drv_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        drv_b(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        repeat (4) tick();

        n_vec++;
        if (ifa.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ready_busy_a: got %b expected 0 (cycle %0d)", ifa.o_busy, cyc);
        end else begin
            $display("chk ready_busy_a = %b ok", ifa.o_busy);
        end
        n_vec++;
        if (ifb.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ready_busy_b: got %b expected 0 (cycle %0d)", ifb.o_busy, cyc);
        end else begin
            $display("chk ready_busy_b = %b ok", ifb.o_busy);
        end

        while (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expectation never checked (due %0d, cycle %0d)",
                     name_q[0], exp_q[0].due, cyc);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
